// File: rtl/vga_scanout.sv
// VGA raster scan-out: sync/blank timing plus a frame-buffer prefetcher feeding a small pixel FIFO.
// hsync/vsync/de/pix_rgb are registered on pix_ce and lag the raster counters by one pixel.
module vga_scanout #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_ce,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  input  logic                  mem_r_valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] pix_rgb,
  output logic                  underflow
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int FA_W      = ADDR_WIDTH + 1;

  localparam logic [HW-1:0]    H_ACT_C     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    H_LAST_C    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    HS_BEG_C    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    HS_END_C    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_ACT_C     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    V_LAST_C    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    VS_BEG_C    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    VS_END_C    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]    V_FLUSH_C   = VW'(V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [FA_W-1:0]  PIX_TOTAL_C = FA_W'(PIX_TOTAL);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fstate_t;

  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  fstate_t               state_q, state_d;
  logic [FA_W-1:0]       fetch_addr_q, fetch_addr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] pix_rgb_q, pix_rgb_d;

  logic h_last_s, v_last_s, active_s, flush_s, fifo_empty_s, push_s, pop_s;

  assign h_last_s     = (hcnt_q == H_LAST_C);
  assign v_last_s     = (vcnt_q == V_LAST_C);
  assign active_s     = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  // Flush on the pixel that steps the raster into the first vsync line.
  assign flush_s      = pix_ce && h_last_s && (vcnt_q == V_FLUSH_C);
  assign fifo_empty_s = (fifo_count_q == {CNT_W{1'b0}});
  assign pop_s        = pix_ce && active_s && !fifo_empty_s;
  assign push_s       = (state_q == F_WAIT) && mem_r_valid && !flush_s;

  assign mem_r_en   = (state_q == F_REQ);
  assign mem_r_addr = fetch_addr_q[ADDR_WIDTH-1:0];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign pix_rgb    = pix_rgb_q;
  assign underflow  = underflow_q;

  // Raster counters advance one pixel per pix_ce.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      if (h_last_s) begin
        hcnt_d = {HW{1'b0}};
        vcnt_d = v_last_s ? {VW{1'b0}} : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // FIFO pointers and occupancy; flush drops everything held.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush_s) begin
      wr_ptr_d     = {PTR_W{1'b0}};
      rd_ptr_d     = {PTR_W{1'b0}};
      fifo_count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  // Fetch FSM: one outstanding read; a missing response means the read was lost, so retry it.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    if (flush_s) begin
      state_d      = F_IDLE;
      fetch_addr_d = {FA_W{1'b0}};
    end else begin
      case (state_q)
        F_IDLE: begin
          if ((fifo_count_q < DEPTH_C) && (fetch_addr_q < PIX_TOTAL_C)) state_d = F_REQ;
          else state_d = F_IDLE;
        end
        F_REQ: state_d = F_WAIT;
        F_WAIT: begin
          if (mem_r_valid) begin
            fetch_addr_d = fetch_addr_q + FA_W'(1);
            // Re-evaluating the idle condition here sustains one pixel every two clocks.
            if ((fifo_count_d < DEPTH_C) && (fetch_addr_d < PIX_TOTAL_C)) state_d = F_REQ;
            else state_d = F_IDLE;
          end else begin
            state_d = F_REQ;
          end
        end
        default: state_d = F_IDLE;
      endcase
    end
  end

  // Registered video outputs, sampled from the counters at each pix_ce.
  always_comb begin
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    de_d        = de_q;
    pix_rgb_d   = pix_rgb_q;
    underflow_d = underflow_q;
    if (pix_ce) begin
      hsync_d   = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
      vsync_d   = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));
      de_d      = active_s;
      pix_rgb_d = pop_s ? fifo_mem[rd_ptr_q] : {DATA_WIDTH{1'b0}};
      if (flush_s)                      underflow_d = 1'b0;
      else if (active_s && fifo_empty_s) underflow_d = 1'b1;
      else                              underflow_d = underflow_q;
    end else begin
      de_d = de_q;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem[wr_ptr_q] <= mem_r_data;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q       <= {HW{1'b0}};
      vcnt_q       <= V_ACT_C;
      state_q      <= F_IDLE;
      fetch_addr_q <= {FA_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      fifo_count_q <= {CNT_W{1'b0}};
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      pix_rgb_q    <= {DATA_WIDTH{1'b0}};
      underflow_q  <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      pix_rgb_q    <= pix_rgb_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 16x4 raster (23x8 total) with a 4-entry FIFO.
// A behavioural memory answers reads one clock later and can drop chosen reads as collisions.
module tb_vga_scanout;

  localparam int AW = 7;
  localparam int DW = 24;
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int FD = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_ce;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data = '0;
  logic          mem_r_valid = 1'b0;
  logic          hsync, vsync, de, underflow;
  logic [DW-1:0] pix_rgb;

  int checks = 0;
  int failures = 0;
  int eh, ev, mode, starved;
  bit uf_cleared;
  bit drop_hi, col_en;
  int col_used = 0, req5 = 0, req_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  vga_scanout #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_rgb(pix_rgb), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix_of(input int a);
    return {8'hA5, a[15:0]};
  endfunction

  always @(posedge clk) begin
    mem_r_valid <= mem_r_en && !(drop_hi && mem_r_addr >= 7'd2)
                   && !(col_en && col_used < 3 && mem_r_addr == 7'd5);
    mem_r_data  <= pix_of(int'(mem_r_addr));
    if (mem_r_en && mem_r_addr == 7'd5) begin
      req5 <= req5 + 1;
      if (col_en && col_used < 3) col_used <= col_used + 1;
    end
    if (mem_r_en) begin
      req_cnt   <= req_cnt + 1;
      last_addr <= mem_r_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_hsync", 32'(hsync), 32'd1);
    check_eq("rst_vsync", 32'(vsync), 32'd1);
    check_eq("rst_de", 32'(de), 32'd0);
    check_eq("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    check_eq("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
  endtask

  task automatic wait_req(output logic [AW-1:0] addr, output bit ok);
    int start;
    start = req_cnt;
    ok = 1'b0;
    addr = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (req_cnt != start) begin
        ok = 1'b1;
        addr = last_addr;
      end
    end
  endtask

  // One pixel: pulse pix_ce, then compare the registered outputs against the reference raster.
  task automatic pix_step(input int gap);
    logic exp_de, exp_hs, exp_vs, flush_now;
    logic [DW-1:0] exp_rgb;
    int ch, cv;
    pix_ce = 1'b1;
    @(posedge clk);
    ch = eh;
    cv = ev;
    exp_de    = (ch < HA) && (cv < VA);
    exp_hs    = !((ch >= HA + HFP) && (ch < HA + HFP + HSW));
    exp_vs    = !((cv >= VA + VFP) && (cv < VA + VFP + VSW));
    exp_rgb   = exp_de ? pix_of(cv * HA + ch) : '0;
    flush_now = (ch == HT - 1) && (cv == VA + VFP - 1);
    if (eh == HT - 1) begin
      eh = 0;
      ev = (ev == VT - 1) ? 0 : ev + 1;
    end else begin
      eh = eh + 1;
    end
    @(negedge clk);
    pix_ce = 1'b0;
    check_eq("de", 32'(de), 32'(exp_de));
    check_eq("hsync", 32'(hsync), 32'(exp_hs));
    check_eq("vsync", 32'(vsync), 32'(exp_vs));
    if (mode == 0) begin
      check_eq("pix_rgb", 32'(pix_rgb), 32'(exp_rgb));
      check_eq("underflow", 32'(underflow), 32'd0);
    end else begin
      if (!exp_de) check_eq("uf_blank_rgb", 32'(pix_rgb), 32'd0);
      else if (pix_rgb == '0) starved++;
      if (ch == 0 && cv == 0) check_eq("uf_first_pix", 32'(pix_rgb), 32'(pix_of(0)));
      if (ch == HA - 1 && cv == 0) check_eq("uf_set", 32'(underflow), 32'd1);
      if (flush_now) uf_cleared = 1'b1;
      if (uf_cleared) check_eq("uf_clear", 32'(underflow), 32'd0);
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] a;
    bit ok, found;
    rst = 1'b1; pix_ce = 1'b0; drop_hi = 1'b0; col_en = 1'b0;
    mode = 0; starved = 0; uf_cleared = 1'b0; eh = 0; ev = VA;
    repeat (3) @(negedge clk);
    check_reset_vals();
    col_en = 1'b1;
    rst = 1'b0;
    wait_req(a, ok);
    check_eq("first_req_seen", 32'(ok), 32'd1);
    check_eq("first_req_addr", 32'(a), 32'd0);

    // Vertical blank then a full frame at one pixel per 4 clocks, with addr 5 colliding 3 times.
    for (int i = 0; i < 4 * HT + VT * HT; i++) pix_step(4);
    check_eq("collision_reqs_addr5", 32'(req5), 32'd4);
    col_en = 1'b0;

    // One frame at a pixel every clock starves the FIFO.
    mode = 1;
    for (int i = 0; i < VT * HT; i++) pix_step(1);
    check_eq("uf_starved_seen", 32'(starved > 0), 32'd1);
    mode = 0;

    // Next frame must restart cleanly at address 0; stop mid-line 2 with the FIFO partly full.
    for (int i = 0; i < 2 * HT + 8; i++) pix_step(4);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    drop_hi = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eh = 0;
    ev = VA;
    wait_req(a, ok);
    check_eq("post_rst_req_seen", 32'(ok), 32'd1);
    check_eq("post_rst_req_addr", 32'(a), 32'd0);

    // Reads from addr 2 keep getting lost; walk the raster up to the flush pixel.
    for (int i = 0; i < HT - 1; i++) pix_step(2);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (mem_r_en) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("inflight_req_seen", 32'(found), 32'd1);
    check_eq("inflight_addr", 32'(mem_r_addr), 32'd2);
    drop_hi = 1'b0;
    @(negedge clk);
    pix_step(1);
    wait_req(a, ok);
    check_eq("post_flush_req_seen", 32'(ok), 32'd1);
    check_eq("post_flush_req_addr", 32'(a), 32'd0);
    for (int i = 0; i < 3 * HT + VT * HT; i++) pix_step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
